// File: rtl/m8c_issp_target.sv
// M8C ISSP target emulator: power-on SDATA handshake, 22-bit vector deserializer, read responder, execute handshake.
// Latency: 3 osc cycles from a pin SCLK rise (or vdd_sense/exec_done change) to the registered response.
// Backpressure: none; the host paces every transfer with SCLK and the target never stalls it.
module m8c_issp_target #(
  parameter int POR_HIGH_CYCLES = 240,
  parameter int POR_LOW_CYCLES  = 24,
  parameter int EXEC_DRAIN_BITS = 40
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic       vdd_sense,
  input  logic       sclk,
  input  logic       sdata_in,
  output logic       sdata_out,
  output logic       sdata_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       exec_start,
  input  logic       exec_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_POR_HI     = 3'd1,
    S_POR_LO     = 3'd2,
    S_IDLE       = 3'd3,
    S_READ       = 3'd4,
    S_EXEC_BUSY  = 3'd5,
    S_EXEC_READY = 3'd6,
    S_EXEC_DRAIN = 3'd7
  } state_t;

  localparam logic [2:0]  OP_WRITE   = 3'b100;
  localparam logic [2:0]  OP_READ    = 3'b101;
  localparam logic [2:0]  OP_EXEC    = 3'b110;
  localparam logic [2:0]  TRAILER_OK = 3'b111;

  localparam logic [15:0] POR_HI_LAST = 16'(POR_HIGH_CYCLES - 1);
  localparam logic [15:0] POR_LO_LAST = 16'(POR_LOW_CYCLES - 1);
  localparam logic [5:0]  DRAIN_LAST  = 6'(EXEC_DRAIN_BITS);

  // Bit-count milestones within a 22-bit vector (count after the rise).
  localparam logic [4:0]  CNT_ADDR_DONE = 5'd11;
  localparam logic [4:0]  CNT_RD_FIRST  = 5'd12;
  localparam logic [4:0]  CNT_RD_LAST   = 5'd19;
  localparam logic [4:0]  CNT_RD_END    = 5'd20;
  localparam logic [4:0]  CNT_VEC_DONE  = 5'd22;

  state_t      st;
  logic        vdd_s1, vdd_s2, vdd_prev;
  logic        sclk_s1, sclk_s2, sclk_prev;
  logic        sd_s1, sd_s2;
  logic        done_s1, done_s2;
  logic [21:0] shreg;
  logic [4:0]  bit_cnt;
  logic [15:0] por_cnt;
  logic [5:0]  drain_cnt;

  logic        rise;
  logic        vdd_rise;
  logic [21:0] shift_next;
  logic [4:0]  bit_next;
  logic [5:0]  drain_next;
  logic [4:0]  rd_pos;

  // Two-flop synchronizers for every asynchronous pin, plus edge-history flops.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      vdd_s1    <= 1'b0;
      vdd_s2    <= 1'b0;
      vdd_prev  <= 1'b0;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      sd_s1     <= 1'b0;
      sd_s2     <= 1'b0;
      done_s1   <= 1'b0;
      done_s2   <= 1'b0;
    end else begin
      vdd_s1    <= vdd_sense;
      vdd_s2    <= vdd_s1;
      vdd_prev  <= vdd_s2;
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sd_s1     <= sdata_in;
      sd_s2     <= sd_s1;
      done_s1   <= exec_done;
      done_s2   <= done_s1;
    end
  end

  // Edge detection and the next shifter/counter values used by the FSM.
  always_comb begin
    rise       = sclk_s2 & ~sclk_prev;
    vdd_rise   = vdd_s2 & ~vdd_prev;
    shift_next = {shreg[20:0], sd_s2};
    bit_next   = bit_cnt + 5'd1;
    drain_next = drain_cnt + 6'd1;
    // Count 12 returns rd_data[7], count 19 returns rd_data[0].
    rd_pos     = CNT_RD_LAST - bit_next;
  end

  // Protocol FSM with registered SDATA drive, strobes and read address.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_OFF;
      sdata_oe   <= 1'b0;
      sdata_out  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 8'h00;
      wr_data    <= 8'h00;
      rd_addr    <= 8'h00;
      exec_start <= 1'b0;
      shreg      <= 22'h0;
      bit_cnt    <= 5'd0;
      por_cnt    <= 16'd0;
      drain_cnt  <= 6'd0;
    end else begin
      wr_en      <= 1'b0;
      exec_start <= 1'b0;
      if (!vdd_s2) begin
        // Power loss wins over everything: drop the pin and forget any partial work.
        st        <= S_OFF;
        sdata_oe  <= 1'b0;
        sdata_out <= 1'b0;
        shreg     <= 22'h0;
        bit_cnt   <= 5'd0;
        por_cnt   <= 16'd0;
        drain_cnt <= 6'd0;
      end else begin
        case (st)
          S_OFF: begin
            sdata_oe  <= 1'b0;
            sdata_out <= 1'b0;
            bit_cnt   <= 5'd0;
            if (vdd_rise) begin
              st        <= S_POR_HI;
              sdata_oe  <= 1'b1;
              sdata_out <= 1'b1;
              por_cnt   <= 16'd0;
            end
          end

          S_POR_HI: begin
            if (por_cnt == POR_HI_LAST) begin
              st        <= S_POR_LO;
              sdata_out <= 1'b0;
              por_cnt   <= 16'd0;
            end else begin
              por_cnt <= por_cnt + 16'd1;
            end
          end

          S_POR_LO: begin
            if (por_cnt == POR_LO_LAST) begin
              st       <= S_IDLE;
              sdata_oe <= 1'b0;
              bit_cnt  <= 5'd0;
              por_cnt  <= 16'd0;
            end else begin
              por_cnt <= por_cnt + 16'd1;
            end
          end

          S_IDLE: begin
            if (rise) begin
              shreg <= shift_next;
              if (bit_next == CNT_VEC_DONE) begin
                bit_cnt <= 5'd0;
                // Vectors with a corrupted trailer are dropped without any side effect.
                if (shift_next[2:0] == TRAILER_OK) begin
                  if (shift_next[21:19] == OP_WRITE) begin
                    wr_en   <= 1'b1;
                    wr_addr <= shift_next[18:11];
                    wr_data <= shift_next[10:3];
                  end else if (shift_next[21:19] == OP_EXEC) begin
                    exec_start <= 1'b1;
                    st         <= S_EXEC_BUSY;
                    sdata_oe   <= 1'b1;
                    sdata_out  <= 1'b1;
                  end
                end
              end else begin
                bit_cnt <= bit_next;
                // Opcode and address are complete: present the address so rd_data settles early.
                if (bit_next == CNT_ADDR_DONE && shift_next[10:8] == OP_READ) begin
                  rd_addr <= shift_next[7:0];
                  st      <= S_READ;
                end
              end
            end
          end

          S_READ: begin
            if (rise) begin
              shreg   <= shift_next;
              bit_cnt <= bit_next;
              if (bit_next >= CNT_RD_FIRST && bit_next <= CNT_RD_LAST) begin
                sdata_oe  <= 1'b1;
                sdata_out <= rd_data[rd_pos[2:0]];
              end else if (bit_next == CNT_RD_END) begin
                // Trailer bits finish in IDLE; opcode 101 there cannot cause a write.
                sdata_oe <= 1'b0;
                st       <= S_IDLE;
              end
            end
          end

          S_EXEC_BUSY: begin
            sdata_oe  <= 1'b1;
            sdata_out <= 1'b1;
            if (done_s2) begin
              st        <= S_EXEC_READY;
              sdata_out <= 1'b0;
            end
          end

          S_EXEC_READY: begin
            if (rise) begin
              sdata_oe  <= 1'b0;
              drain_cnt <= 6'd1;
              st        <= S_EXEC_DRAIN;
            end
          end

          S_EXEC_DRAIN: begin
            if (rise) begin
              if (drain_next == DRAIN_LAST) begin
                drain_cnt <= 6'd0;
                bit_cnt   <= 5'd0;
                st        <= S_IDLE;
              end else begin
                drain_cnt <= drain_next;
              end
            end
          end

          default: st <= S_OFF;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_m8c_issp_target.sv
// Directed bench for m8c_issp_target with an event-schedule reference model and per-cycle compare.
// Latency: the model places every pin-driven effect 3 osc cycles after the pin change.
// Backpressure: none; the bench acts as ISSP host with a 6+6 cycle SCLK.
module tb_m8c_issp_target;

  logic       osc = 1'b0;
  logic       rst_n = 1'b0;
  logic       vdd_sense = 1'b0;
  logic       sclk = 1'b0;
  logic       sdata_in = 1'b0;
  logic       exec_done = 1'b0;
  logic [7:0] rd_data;
  logic       sdata_out, sdata_oe, wr_en, exec_start;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [2:0] state;

  always #5 osc = ~osc;

  m8c_issp_target dut (
    .osc(osc), .rst_n(rst_n), .vdd_sense(vdd_sense), .sclk(sclk), .sdata_in(sdata_in),
    .sdata_out(sdata_out), .sdata_oe(sdata_oe), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .exec_start(exec_start),
    .exec_done(exec_done), .state(state)
  );

  // Register file stand-in: contents are a fixed function of the address (0x10 -> 0xA5).
  assign rd_data = rd_addr ^ 8'hB5;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge osc) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: scheduled changes of the expected outputs.
  localparam int K_STATE = 0, K_OE = 1, K_OUT = 2, K_WR = 3, K_WR_CLR = 4, K_EX = 5, K_EX_CLR = 6;
  typedef struct {int t; int kind; int val;} ev_t;
  ev_t evq[$];

  task automatic sched(input int t, input int kind, input int val);
    ev_t ev;
    ev.t = t; ev.kind = kind; ev.val = val;
    evq.push_back(ev);
  endtask

  int e_state = 0, e_oe = 0, e_out = 0, e_wr = 0, e_wa = 0, e_wd = 0, e_ex = 0;

  // Apply due model events, then compare every DUT output against the expectation.
  always @(negedge osc) begin : cmp
    int i;
    i = 0;
    while (i < evq.size()) begin
      if (evq[i].t <= cyc) begin
        case (evq[i].kind)
          K_STATE:  e_state = evq[i].val;
          K_OE:     e_oe = evq[i].val;
          K_OUT:    e_out = evq[i].val;
          K_WR:     begin e_wr = 1; e_wa = (evq[i].val >> 8) & 255; e_wd = evq[i].val & 255; end
          K_WR_CLR: e_wr = 0;
          K_EX:     e_ex = 1;
          K_EX_CLR: e_ex = 0;
          default:  ;
        endcase
        evq.delete(i);
      end else begin
        i++;
      end
    end
    if (cyc >= 1) begin
      check("state", 32'(state), e_state);
      check("sdata_oe", 32'(sdata_oe), e_oe);
      if (e_oe != 0) check("sdata_out", 32'(sdata_out), e_out);
      check("wr_en", 32'(wr_en), e_wr);
      if (e_wr != 0) begin
        check("wr_addr", 32'(wr_addr), e_wa);
        check("wr_data", 32'(wr_data), e_wd);
      end
      check("exec_start", 32'(exec_start), e_ex);
    end
  end

  // Strobe monitor used by the hand-computed checks.
  int wr_cnt = 0, ex_cnt = 0;
  logic [7:0] last_wa = 8'h00, last_wd = 8'h00;
  always @(negedge osc) begin
    if (wr_en === 1'b1) begin wr_cnt++; last_wa = wr_addr; last_wd = wr_data; end
    if (exec_start === 1'b1) ex_cnt++;
  end

  // Model state in protocol terms: 0 off, 3 idle, 4 read, 5 busy, 6 ready, 7 drain.
  int m_mode = 0, m_cnt = 0, m_drain = 0, m_raddr = 0;
  logic [21:0] m_vec = 22'h0;

  task automatic model_rise(input int n, input logic b);
    int e, pos, rv;
    e = n + 3;
    case (m_mode)
      3: begin
        m_vec = {m_vec[20:0], b};
        m_cnt++;
        if (m_cnt == 11 && m_vec[10:8] == 3'b101) begin
          m_mode = 4; m_raddr = int'(m_vec[7:0]); sched(e, K_STATE, 4);
        end
        if (m_cnt == 22) begin
          m_cnt = 0;
          if (m_vec[2:0] == 3'b111 && m_vec[21:19] == 3'b100) begin
            sched(e, K_WR, int'(m_vec[18:3])); sched(e + 1, K_WR_CLR, 0);
          end else if (m_vec[2:0] == 3'b111 && m_vec[21:19] == 3'b110) begin
            sched(e, K_EX, 0); sched(e + 1, K_EX_CLR, 0);
            sched(e, K_STATE, 5); sched(e, K_OE, 1); sched(e, K_OUT, 1);
            m_mode = 5;
            if (exec_done) begin
              sched(e + 1, K_STATE, 6); sched(e + 1, K_OUT, 0); m_mode = 6;
            end
          end
        end
      end
      4: begin
        m_vec = {m_vec[20:0], b};
        m_cnt++;
        pos = 22 - m_cnt;
        rv = m_raddr ^ 'hB5;
        if (pos >= 3 && pos <= 10) begin
          sched(e, K_OE, 1); sched(e, K_OUT, (rv >> (pos - 3)) & 1);
        end else if (pos == 2) begin
          sched(e, K_OE, 0); sched(e, K_STATE, 3); m_mode = 3;
        end
      end
      6: begin
        sched(e, K_OE, 0); sched(e, K_STATE, 7); m_drain = 1; m_mode = 7;
      end
      7: begin
        m_drain++;
        if (m_drain == 40) begin sched(e, K_STATE, 3); m_mode = 3; m_cnt = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge osc);
  endtask

  task automatic send_bit(input logic b);
    @(negedge osc);
    sclk = 1'b0;
    sdata_in = b;
    tick(6);
    sclk = 1'b1;
    model_rise(cyc, b);
    tick(5);
  endtask

  task automatic send_vec(input logic [21:0] v);
    for (int i = 21; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic vdd_up();
    int n;
    n = cyc;
    vdd_sense = 1'b1;
    sched(n + 3, K_STATE, 1); sched(n + 3, K_OE, 1); sched(n + 3, K_OUT, 1);
    sched(n + 243, K_STATE, 2); sched(n + 243, K_OUT, 0);
    sched(n + 267, K_STATE, 3); sched(n + 267, K_OE, 0);
    m_mode = 3; m_cnt = 0; m_vec = 22'h0;
  endtask

  task automatic vdd_down();
    int n;
    n = cyc;
    vdd_sense = 1'b0;
    sched(n + 3, K_STATE, 0); sched(n + 3, K_OE, 0);
    m_mode = 0; m_cnt = 0;
  endtask

  task automatic raise_done();
    int n;
    n = cyc;
    exec_done = 1'b1;
    if (m_mode == 5) begin
      sched(n + 3, K_STATE, 6); sched(n + 3, K_OUT, 0); m_mode = 6;
    end
  endtask

  // Power up and measure the handshake lengths straight from the pins.
  task automatic power_up_and_measure();
    int hi, lo;
    hi = 0; lo = 0;
    @(negedge osc);
    vdd_up();
    for (int i = 0; i < 290; i++) begin
      @(negedge osc);
      if (sdata_oe === 1'b1 && sdata_out === 1'b1) hi++;
      if (sdata_oe === 1'b1 && sdata_out === 1'b0) lo++;
    end
    check("por_high_len", hi, 240);
    check("por_low_len", lo, 24);
    check("post_por_state", 32'(state), 3);
  endtask

  initial begin
    logic [7:0] rbits;
    int wr0;

    tick(3);
    check("reset_state", 32'(state), 0);
    check("reset_oe", 32'(sdata_oe), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    rst_n = 1'b1;
    tick(5);

    power_up_and_measure();

    // Write 0x5C to 0x3A.
    send_vec({3'b100, 8'h3A, 8'h5C, 3'b111});
    check("write_count", wr_cnt, 1);
    check("write_addr", 32'(last_wa), 32'h3A);
    check("write_data", 32'(last_wd), 32'h5C);

    // Read 0x10; register file returns 0xA5.
    begin
      logic [21:0] v;
      v = {3'b101, 8'h10, 8'h00, 3'b111};
      rbits = 8'h00;
      for (int i = 21; i >= 0; i--) begin
        send_bit(v[i]);
        if (i <= 10 && i >= 3) rbits = {rbits[6:0], sdata_out};
        if (i == 2) check("read_oe_released", 32'(sdata_oe), 0);
      end
    end
    check("read_rd_addr", 32'(rd_addr), 32'h10);
    check("read_bits", 32'(rbits), 32'hA5);
    check("read_no_write", wr_cnt, 1);

    // Corrupted trailer, then a good write back to back.
    send_vec({3'b100, 8'h01, 8'hFF, 3'b110});
    check("bad_trailer_no_write", wr_cnt, 1);
    send_vec({3'b100, 8'h02, 8'h33, 3'b111});
    check("after_bad_write_count", wr_cnt, 2);
    check("after_bad_write_addr", 32'(last_wa), 32'h02);

    // Execute: busy through 40 host clocks, then ready, then 40 drained rises.
    send_vec({3'b110, 8'h00, 8'h00, 3'b111});
    check("exec_pulse_count", ex_cnt, 1);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    check("exec_busy_state", 32'(state), 5);
    check("exec_busy_sdata", 32'(sdata_out), 1);
    raise_done();
    tick(5);
    check("exec_ready_state", 32'(state), 6);
    check("exec_ready_sdata", 32'(sdata_out), 0);
    for (int i = 0; i < 40; i++) send_bit(1'b1);
    check("exec_drained_state", 32'(state), 3);
    exec_done = 1'b0;
    send_vec({3'b100, 8'h20, 8'h77, 3'b111});
    check("post_exec_write_count", wr_cnt, 3);
    check("post_exec_write_data", 32'(last_wd), 32'h77);

    // exec_done already high when the execute vector lands.
    exec_done = 1'b1;
    tick(10);
    send_vec({3'b110, 8'hAA, 8'h55, 3'b111});
    check("exec2_pulse_count", ex_cnt, 2);
    check("exec2_ready_state", 32'(state), 6);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    check("exec2_drained_state", 32'(state), 3);
    exec_done = 1'b0;

    // Power loss in the middle of a write.
    wr0 = wr_cnt;
    begin
      logic [21:0] v;
      v = {3'b100, 8'h44, 8'h11, 3'b111};
      for (int i = 21; i >= 10; i--) send_bit(v[i]);
    end
    @(negedge osc);
    vdd_down();
    tick(3);
    check("vdd_drop_state", 32'(state), 0);
    check("vdd_drop_oe", 32'(sdata_oe), 0);
    tick(20);
    check("vdd_drop_no_write", wr_cnt, wr0);
    power_up_and_measure();
    send_vec({3'b100, 8'h55, 8'h66, 3'b111});
    check("repower_write_count", wr_cnt, wr0 + 1);
    check("repower_write_addr", 32'(last_wa), 32'h55);

    tick(10);
    check("model_events_drained", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
